// File: rtl/ws_array_ctrl.sv
// ws_array_ctrl: job sequencer for a ROWS x COLS weight-stationary PE array.
// Walks IDLE -> LOAD_F -> STREAM -> DRAIN -> DONE, generating the filter row
// latch enables, the row-skewed ifmap window and the per-column psum tags.
module ws_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_num_vec,
    input  logic             abort,
    input  logic             filt_valid,
    output logic             filt_ready,
    output logic [ROWS-1:0]  load_f,
    input  logic             ifmap_valid,
    output logic             ifmap_ready,
    output logic [ROWS-1:0]  load_i,
    output logic             start,
    output logic [COLS-1:0]  psum_valid,
    output logic             busy,
    output logic             done
);

    // Tag k cycles old sits in tag_sr[k-1]; column c reads the tag that is
    // ROWS+c cycles old, so the oldest column needs ROWS+COLS-1 stages.
    localparam int SRW = ROWS + COLS - 1;

    typedef enum logic [2:0] {IDLE, LOAD_F, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] num_vec;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] s_cnt;
    logic [SRW-1:0]   tag_sr;
    logic             filt_beat;
    logic             accept;
    logic             in_window;

    // An abort in the same cycle wins over any handshake.
    assign filt_beat   = (state == LOAD_F) && filt_valid && !abort;
    assign accept      = ifmap_valid && ifmap_ready && !abort;
    assign in_window   = (state == STREAM) || (state == DRAIN);

    assign cfg_ready   = (state == IDLE);
    assign filt_ready  = (state == LOAD_F);
    assign ifmap_ready = (state == STREAM) && (acc_cnt < num_vec);
    assign start       = in_window;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign psum_valid  = tag_sr[ROWS-1 +: COLS];

    // Per-row enables: filter latch is one-hot on the current row, ifmap
    // window opens one row per cycle after STREAM entry and stays open.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign load_f[r] = filt_beat && (row_cnt == CNT_W'(r));
        assign load_i[r] = in_window && (s_cnt >= CNT_W'(r));
    end

    // Sequencer state, counters and the psum tag shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            num_vec <= '0;
            row_cnt <= '0;
            acc_cnt <= '0;
            s_cnt   <= '0;
            tag_sr  <= '0;
        end else if (abort && state != IDLE) begin
            state   <= IDLE;
            row_cnt <= '0;
            acc_cnt <= '0;
            s_cnt   <= '0;
            tag_sr  <= '0;
        end else begin
            tag_sr <= {tag_sr[SRW-2:0], accept};
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        num_vec <= cfg_num_vec;
                        row_cnt <= '0;
                        acc_cnt <= '0;
                        s_cnt   <= '0;
                        state   <= LOAD_F;
                    end
                end
                LOAD_F: begin
                    if (filt_beat) begin
                        if (row_cnt == CNT_W'(ROWS - 1)) begin
                            s_cnt <= '0;
                            state <= (num_vec == '0) ? DONE : STREAM;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (s_cnt != CNT_W'(ROWS)) s_cnt <= s_cnt + 1'b1;
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                        if (acc_cnt + 1'b1 == num_vec) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s_cnt != CNT_W'(ROWS)) s_cnt <= s_cnt + 1'b1;
                    // Only the tag being emitted on the last column remains.
                    if (tag_sr[SRW-2:0] == '0) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws_array_ctrl.sv
// tb_ws_array_ctrl: directed, table-driven check of ws_array_ctrl (4x4 array).
// Each record is one clock cycle: inputs driven at negedge, outputs compared
// 1 time unit later, state advances on the following posedge.
module tb_ws_array_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_num_vec;
    logic             abort;
    logic             filt_valid;
    logic             filt_ready;
    logic [ROWS-1:0]  load_f;
    logic             ifmap_valid;
    logic             ifmap_ready;
    logic [ROWS-1:0]  load_i;
    logic             start;
    logic [COLS-1:0]  psum_valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_vec(cfg_num_vec),
        .abort(abort),
        .filt_valid(filt_valid), .filt_ready(filt_ready), .load_f(load_f),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .load_i(load_i),
        .start(start), .psum_valid(psum_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Output vector layout:
    // {cfg_ready, filt_ready, load_f[3:0], ifmap_ready, load_i[3:0], start, psum_valid[3:0], busy, done}
    typedef struct {
        logic        cv;
        logic [7:0]  nv;
        logic        ab;
        logic        fv;
        logic        iv;
        logic [17:0] exp;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [17:0] e_idle();
        return {1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    endfunction
    function automatic logic [17:0] e_ld(input logic [3:0] lf);
        return {1'b0, 1'b1, lf, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
    endfunction
    function automatic logic [17:0] e_st(input logic ir, input logic [3:0] li, input logic [3:0] ps);
        return {1'b0, 1'b0, 4'b0000, ir, li, 1'b1, ps, 1'b1, 1'b0};
    endfunction
    function automatic logic [17:0] e_dn();
        return {1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1};
    endfunction

    task automatic add(input string tag, input logic cv, input logic [7:0] nv, input logic ab,
                       input logic fv, input logic iv, input logic [17:0] exp);
        vec_t v;
        v.tag = tag; v.cv = cv; v.nv = nv; v.ab = ab; v.fv = fv; v.iv = iv; v.exp = exp;
        tbl.push_back(v);
    endtask

    function automatic logic [17:0] observe();
        return {cfg_ready, filt_ready, load_f, ifmap_ready, load_i, start, psum_valid, busy, done};
    endfunction

    task automatic check(input string tag, input logic [17:0] exp);
        logic [17:0] got;
        got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            cfg_valid   = tbl[i].cv;
            cfg_num_vec = tbl[i].nv;
            abort       = tbl[i].ab;
            filt_valid  = tbl[i].fv;
            ifmap_valid = tbl[i].iv;
            #1;
            check(tbl[i].tag, tbl[i].exp);
        end
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_num_vec = '0; abort = 0; filt_valid = 0; ifmap_valid = 0;
        #12;
        check("reset", e_idle());
        @(negedge clk); rst = 1'b0;

        // num_vec=3, back-to-back filter, continuous ifmap.
        add("s2 idle",  1, 8'd3, 0, 0, 0, e_idle());
        add("s2 lf0",   0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s2 lf1",   0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s2 lf2",   0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s2 lf3",   0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s2 t0",    0, 8'd0, 0, 0, 1, e_st(1, 4'b0001, 4'b0000));
        add("s2 t0+1",  0, 8'd0, 0, 0, 1, e_st(1, 4'b0011, 4'b0000));
        add("s2 t0+2",  0, 8'd0, 0, 0, 1, e_st(1, 4'b0111, 4'b0000));
        add("s2 t0+3",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b0000));
        add("s2 t0+4",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b0001));
        add("s2 t0+5",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b0011));
        add("s2 t0+6",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b0111));
        add("s2 t0+7",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b1110));
        add("s2 t0+8",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b1100));
        add("s2 t0+9",  0, 8'd0, 0, 0, 1, e_st(0, 4'b1111, 4'b1000));
        add("s2 done",  0, 8'd0, 0, 0, 0, e_dn());
        add("s2 idle2", 0, 8'd0, 0, 0, 0, e_idle());

        // Gapped filter beats, then abort in STREAM.
        add("s3 idle",  1, 8'd1, 0, 0, 0, e_idle());
        add("s3 b1",    0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s3 gap1",  0, 8'd0, 0, 0, 0, e_ld(4'b0000));
        add("s3 b2",    0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s3 b3",    0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s3 gap2",  0, 8'd0, 0, 0, 0, e_ld(4'b0000));
        add("s3 b4",    0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s3 strm",  0, 8'd0, 1, 0, 0, e_st(1, 4'b0001, 4'b0000));
        add("s3 abidl", 0, 8'd0, 0, 0, 0, e_idle());

        // num_vec=2 with a bubble between the two vectors.
        add("s4 idle",  1, 8'd2, 0, 0, 0, e_idle());
        add("s4 lf0",   0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s4 lf1",   0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s4 lf2",   0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s4 lf3",   0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s4 t0",    0, 8'd0, 0, 0, 1, e_st(1, 4'b0001, 4'b0000));
        add("s4 t0+1",  0, 8'd0, 0, 0, 0, e_st(1, 4'b0011, 4'b0000));
        add("s4 t0+2",  0, 8'd0, 0, 0, 1, e_st(1, 4'b0111, 4'b0000));
        add("s4 t0+3",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b0000));
        add("s4 t0+4",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b0001));
        add("s4 t0+5",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b0010));
        add("s4 t0+6",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b0101));
        add("s4 t0+7",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b1010));
        add("s4 t0+8",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b0100));
        add("s4 t0+9",  0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b1000));
        add("s4 done",  0, 8'd0, 0, 0, 0, e_dn());
        add("s4 idle2", 1, 8'd0, 0, 0, 0, e_idle());

        // num_vec=0 (cfg accepted on previous row): filter then straight to DONE.
        add("s5 lf0",   0, 8'd0, 0, 1, 1, e_ld(4'b0001));
        add("s5 lf1",   0, 8'd0, 0, 1, 1, e_ld(4'b0010));
        add("s5 lf2",   0, 8'd0, 0, 1, 1, e_ld(4'b0100));
        add("s5 lf3",   0, 8'd0, 0, 1, 1, e_ld(4'b1000));
        add("s5 done",  0, 8'd0, 0, 0, 1, e_dn());
        add("s5 idle",  0, 8'd0, 0, 0, 1, e_idle());

        // Abort in DRAIN just as the first tag emerges; abort ignored in IDLE.
        add("s6 idle",  1, 8'd1, 0, 0, 0, e_idle());
        add("s6 lf0",   0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s6 lf1",   0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s6 lf2",   0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s6 lf3",   0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s6 t0",    0, 8'd0, 0, 0, 1, e_st(1, 4'b0001, 4'b0000));
        add("s6 dr1",   0, 8'd0, 0, 0, 0, e_st(0, 4'b0011, 4'b0000));
        add("s6 dr2",   0, 8'd0, 0, 0, 0, e_st(0, 4'b0111, 4'b0000));
        add("s6 dr3",   0, 8'd0, 0, 0, 0, e_st(0, 4'b1111, 4'b0000));
        add("s6 abort", 0, 8'd0, 1, 0, 0, e_st(0, 4'b1111, 4'b0001));
        add("s6 ab+1",  0, 8'd0, 1, 0, 0, e_idle());
        add("s6 ab+2",  0, 8'd0, 0, 0, 0, e_idle());

        // Abort colliding with a filter beat: beat dropped, next job restarts at row 0.
        add("s6b idle", 1, 8'd1, 0, 0, 0, e_idle());
        add("s6b lf0",  0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s6b ablf", 0, 8'd0, 1, 1, 0, e_ld(4'b0000));
        add("s6b idle2",1, 8'd0, 0, 0, 0, e_idle());
        add("s6b lf0b", 0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s6b lf1b", 0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s6b lf2b", 0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s6b lf3b", 0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s6b done", 0, 8'd0, 0, 0, 0, e_dn());
        run_table();

        // Asynchronous reset mid-STREAM: outputs clear before the next edge.
        add("s1 idle",  1, 8'd5, 0, 0, 0, e_idle());
        add("s1 lf0",   0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s1 lf1",   0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s1 lf2",   0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s1 lf3",   0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s1 t0",    0, 8'd0, 0, 0, 1, e_st(1, 4'b0001, 4'b0000));
        add("s1 t0+1",  0, 8'd0, 0, 0, 1, e_st(1, 4'b0011, 4'b0000));
        run_table();
        #2;
        rst = 1'b1; ifmap_valid = 1'b0;
        #1;
        check("s1 async rst", e_idle());
        @(negedge clk); rst = 1'b0;
        add("s1 re-idle", 1, 8'd1, 0, 0, 0, e_idle());
        add("s1 re-lf0",  0, 8'd0, 0, 1, 0, e_ld(4'b0001));
        add("s1 re-lf1",  0, 8'd0, 0, 1, 0, e_ld(4'b0010));
        add("s1 re-lf2",  0, 8'd0, 0, 1, 0, e_ld(4'b0100));
        add("s1 re-lf3",  0, 8'd0, 0, 1, 0, e_ld(4'b1000));
        add("s1 re-t0",   0, 8'd0, 0, 0, 1, e_st(1, 4'b0001, 4'b0000));
        add("s1 re-dr",   0, 8'd0, 0, 0, 0, e_st(0, 4'b0011, 4'b0000));
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
